// File: rtl/svc_rv_cache_arb_if.sv
// Bundle of the I/D requester ports and the shared cache port.
// slave is the arbiter's view; master is the surrounding environment's view.
interface svc_rv_cache_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    i_rd_valid;
    logic                    i_rd_ready;
    logic [ADDR_WIDTH-1:0]   i_rd_addr;
    logic [DATA_WIDTH-1:0]   i_rd_data;
    logic                    i_rd_data_valid;

    logic                    d_rd_valid;
    logic                    d_rd_ready;
    logic [ADDR_WIDTH-1:0]   d_rd_addr;
    logic [DATA_WIDTH-1:0]   d_rd_data;
    logic                    d_rd_data_valid;

    logic                    d_wr_valid;
    logic                    d_wr_ready;
    logic [ADDR_WIDTH-1:0]   d_wr_addr;
    logic [DATA_WIDTH-1:0]   d_wr_data;
    logic [DATA_WIDTH/8-1:0] d_wr_strb;

    logic                    c_rd_valid;
    logic                    c_rd_ready;
    logic [ADDR_WIDTH-1:0]   c_rd_addr;
    logic [DATA_WIDTH-1:0]   c_rd_data;
    logic                    c_rd_data_valid;

    logic                    c_wr_valid;
    logic                    c_wr_ready;
    logic [ADDR_WIDTH-1:0]   c_wr_addr;
    logic [DATA_WIDTH-1:0]   c_wr_data;
    logic [DATA_WIDTH/8-1:0] c_wr_strb;

    modport slave (
        input  i_rd_valid, i_rd_addr,
        output i_rd_ready, i_rd_data, i_rd_data_valid,
        input  d_rd_valid, d_rd_addr,
        output d_rd_ready, d_rd_data, d_rd_data_valid,
        input  d_wr_valid, d_wr_addr, d_wr_data, d_wr_strb,
        output d_wr_ready,
        output c_rd_valid, c_rd_addr,
        input  c_rd_ready, c_rd_data, c_rd_data_valid,
        output c_wr_valid, c_wr_addr, c_wr_data, c_wr_strb,
        input  c_wr_ready
    );

    modport master (
        output i_rd_valid, i_rd_addr,
        input  i_rd_ready, i_rd_data, i_rd_data_valid,
        output d_rd_valid, d_rd_addr,
        input  d_rd_ready, d_rd_data, d_rd_data_valid,
        output d_wr_valid, d_wr_addr, d_wr_data, d_wr_strb,
        input  d_wr_ready,
        input  c_rd_valid, c_rd_addr,
        output c_rd_ready, c_rd_data, c_rd_data_valid,
        input  c_wr_valid, c_wr_addr, c_wr_data, c_wr_strb,
        output c_wr_ready
    );
endinterface

// File: rtl/svc_rv_cache_arb.sv
// Round-robin arbiter sharing one cache port between instruction fetch (I)
// and the data bridge (D), with a single transaction outstanding at a time.
module svc_rv_cache_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    svc_rv_cache_arb_if.slave   bus
);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_RESP, WR_REQ} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} own_t;

    state_t                state_q, state_d;
    own_t                  owner_q, owner_d;
    own_t                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic                  c_rd_valid_q, c_rd_valid_d;
    logic                  c_wr_valid_q, c_wr_valid_d;

    logic i_cand, d_cand, idle, grant_i, grant_d;

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    assign i_cand  = bus.i_rd_valid;
    assign d_cand  = bus.d_wr_valid | bus.d_rd_valid;
    assign idle    = (state_q == IDLE) && rst_n;
    assign grant_i = idle && i_cand && (!d_cand || last_q == OWN_D);
    assign grant_d = idle && d_cand && (!i_cand || last_q == OWN_I);

    assign bus.i_rd_ready = grant_i;
    assign bus.d_wr_ready = grant_d && bus.d_wr_valid;
    assign bus.d_rd_ready = grant_d && !bus.d_wr_valid && bus.d_rd_valid;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        strb_d       = strb_q;
        c_rd_valid_d = c_rd_valid_q;
        c_wr_valid_d = c_wr_valid_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    owner_d      = OWN_I;
                    last_d       = OWN_I;
                    addr_d       = bus.i_rd_addr;
                    state_d      = RD_REQ;
                    c_rd_valid_d = 1'b1;
                end else if (grant_d) begin
                    owner_d = OWN_D;
                    last_d  = OWN_D;
                    if (bus.d_wr_valid) begin
                        addr_d       = bus.d_wr_addr;
                        wdata_d      = bus.d_wr_data;
                        strb_d       = bus.d_wr_strb;
                        state_d      = WR_REQ;
                        c_wr_valid_d = 1'b1;
                    end else begin
                        addr_d       = bus.d_rd_addr;
                        state_d      = RD_REQ;
                        c_rd_valid_d = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (bus.c_rd_ready) begin
                    state_d      = RD_RESP;
                    c_rd_valid_d = 1'b0;
                end
            end
            RD_RESP: begin
                if (bus.c_rd_data_valid) begin
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                if (bus.c_wr_ready) begin
                    state_d      = IDLE;
                    c_wr_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_q       <= OWN_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            c_rd_valid_q <= 1'b0;
            c_wr_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            strb_q       <= strb_d;
            c_rd_valid_q <= c_rd_valid_d;
            c_wr_valid_q <= c_wr_valid_d;
        end
    end

    assign bus.c_rd_valid = c_rd_valid_q;
    assign bus.c_rd_addr  = addr_q;
    assign bus.c_wr_valid = c_wr_valid_q;
    assign bus.c_wr_addr  = addr_q;
    assign bus.c_wr_data  = wdata_q;
    assign bus.c_wr_strb  = strb_q;

    // Response strobe is routed only to the owner, and only while in RD_RESP.
    assign bus.i_rd_data       = bus.c_rd_data;
    assign bus.d_rd_data       = bus.c_rd_data;
    assign bus.i_rd_data_valid = rst_n && (state_q == RD_RESP) && bus.c_rd_data_valid
                                 && (owner_q == OWN_I);
    assign bus.d_rd_data_valid = rst_n && (state_q == RD_RESP) && bus.c_rd_data_valid
                                 && (owner_q == OWN_D);
endmodule

// File: tb/tb_svc_rv_cache_arb.sv
// Directed bench for svc_rv_cache_arb: per-cycle vector table plus a
// hand-written reset-during-response sequence.
module tb_svc_rv_cache_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   row = -1;

    always #5 clk = ~clk;

    svc_rv_cache_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    svc_rv_cache_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rn;
        logic        iv;   logic [31:0] ia;
        logic        drv;  logic [31:0] dra;
        logic        dwv;  logic [31:0] dwa; logic [31:0] dwd; logic [3:0] dws;
        logic        crr;  logic [31:0] crd; logic crdv; logic cwr;
        logic        e_ir; logic e_drr; logic e_dwr;
        logic        e_crv; logic [31:0] e_cra;
        logic        e_cwv; logic [31:0] e_cwa; logic [31:0] e_cwd; logic [3:0] e_cws;
        logic        e_idv; logic e_ddv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic rn, logic iv, logic [31:0] ia, logic drv, logic [31:0] dra,
        logic dwv, logic [31:0] dwa, logic [31:0] dwd, logic [3:0] dws,
        logic crr, logic [31:0] crd, logic crdv, logic cwr,
        logic e_ir, logic e_drr, logic e_dwr, logic e_crv, logic [31:0] e_cra,
        logic e_cwv, logic [31:0] e_cwa, logic [31:0] e_cwd, logic [3:0] e_cws,
        logic e_idv, logic e_ddv);
        vec_t v;
        v.rn = rn; v.iv = iv; v.ia = ia; v.drv = drv; v.dra = dra;
        v.dwv = dwv; v.dwa = dwa; v.dwd = dwd; v.dws = dws;
        v.crr = crr; v.crd = crd; v.crdv = crdv; v.cwr = cwr;
        v.e_ir = e_ir; v.e_drr = e_drr; v.e_dwr = e_dwr;
        v.e_crv = e_crv; v.e_cra = e_cra;
        v.e_cwv = e_cwv; v.e_cwa = e_cwa; v.e_cwd = e_cwd; v.e_cws = e_cws;
        v.e_idv = e_idv; v.e_ddv = e_ddv;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h, expected %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n               = v.rn;
        bus.i_rd_valid      = v.iv;  bus.i_rd_addr = v.ia;
        bus.d_rd_valid      = v.drv; bus.d_rd_addr = v.dra;
        bus.d_wr_valid      = v.dwv; bus.d_wr_addr = v.dwa;
        bus.d_wr_data       = v.dwd; bus.d_wr_strb = v.dws;
        bus.c_rd_ready      = v.crr; bus.c_rd_data = v.crd;
        bus.c_rd_data_valid = v.crdv;
        bus.c_wr_ready      = v.cwr;
    endtask

    task automatic compare(input vec_t v);
        check("i_rd_ready", 32'(bus.i_rd_ready), 32'(v.e_ir));
        check("d_rd_ready", 32'(bus.d_rd_ready), 32'(v.e_drr));
        check("d_wr_ready", 32'(bus.d_wr_ready), 32'(v.e_dwr));
        check("c_rd_valid", 32'(bus.c_rd_valid), 32'(v.e_crv));
        if (v.e_crv) check("c_rd_addr", bus.c_rd_addr, v.e_cra);
        check("c_wr_valid", 32'(bus.c_wr_valid), 32'(v.e_cwv));
        if (v.e_cwv) begin
            check("c_wr_addr", bus.c_wr_addr, v.e_cwa);
            check("c_wr_data", bus.c_wr_data, v.e_cwd);
            check("c_wr_strb", 32'(bus.c_wr_strb), 32'(v.e_cws));
        end
        check("i_rd_data_valid", 32'(bus.i_rd_data_valid), 32'(v.e_idv));
        check("d_rd_data_valid", 32'(bus.d_rd_data_valid), 32'(v.e_ddv));
        if (v.e_idv) check("i_rd_data", bus.i_rd_data, v.crd);
        if (v.e_ddv) check("d_rd_data", bus.d_rd_data, v.crd);
    endtask

    vec_t z;

    initial begin
        z = mk(1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0);
        // I-only read
        vecs.push_back(mk(1,1,'h1000,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,1,0,0,0, 0,0,0,1,'h1000,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,'hCAFEBABE,1,0, 0,0,0,0,0,0,0,0,0,1,0));
        vecs.push_back(z);
        // reset held with requests pending, then tie I/D alternating I,D,I,D
        vecs.push_back(mk(0,1,'h100,1,'h200,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,'h100,1,'h200,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,'h100,1,'h200,0,0,0,0,1,0,0,0, 0,0,0,1,'h100,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,'h100,1,'h200,0,0,0,0,0,'hAAAA0001,1,0, 0,0,0,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(1,1,'h100,1,'h200,0,0,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,'h100,1,'h200,0,0,0,0,1,0,0,0, 0,0,0,1,'h200,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,'h100,1,'h200,0,0,0,0,0,'hBBBB0002,1,0, 0,0,0,0,0,0,0,0,0,0,1));
        vecs.push_back(mk(1,1,'h100,1,'h200,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,'h100,1,'h200,0,0,0,0,1,0,0,0, 0,0,0,1,'h100,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,'h100,1,'h200,0,0,0,0,0,'hAAAA0003,1,0, 0,0,0,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(1,1,'h100,1,'h200,0,0,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,'h100,1,'h200,0,0,0,0,1,0,0,0, 0,0,0,1,'h200,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,'h100,1,'h200,0,0,0,0,0,'hBBBB0004,1,0, 0,0,0,0,0,0,0,0,0,0,1));
        vecs.push_back(z);
        // D write with c_wr_ready stalled 3 cycles
        vecs.push_back(mk(1,0,0,0,0,1,'h3000,'h12345678,'hF,0,0,0,0, 0,0,1,0,0,0,0,0,0,0,0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1,0,0,0,0,0,'h9999,'h0,'h0,0,0,0,0, 0,0,0,0,0,1,'h3000,'h12345678,'hF,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,1,'h3000,'h12345678,'hF,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0,0,0,0));
        // D write and read together: write first, read after
        vecs.push_back(mk(1,0,0,1,'h4000,1,'h4000,'h55AA55AA,'h3,0,0,0,0, 0,0,1,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,1,'h4000,0,0,0,0,0,0,0,1, 0,0,0,0,0,1,'h4000,'h55AA55AA,'h3,0,0));
        vecs.push_back(mk(1,0,0,1,'h4000,0,0,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,1,0,0,0, 0,0,0,1,'h4000,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,'h55AA55AA,1,0, 0,0,0,0,0,0,0,0,0,0,1));
        // stalled c_rd_ready with stray data_valid in RD_REQ
        vecs.push_back(mk(1,1,'h5000,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,'hDEAD0000,1,0, 0,0,0,1,'h5000,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,1,'h5000,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,1,'h5000,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,'hDEAD0001,1,0, 0,0,0,1,'h5000,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,1,0,0,0, 0,0,0,1,'h5000,0,0,0,0,0,0));
        vecs.push_back(z);
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,'h600DF00D,1,0, 0,0,0,0,0,0,0,0,0,1,0));
        vecs.push_back(z);

        // Power-on reset with I requesting: ready must stay low
        drive(mk(0,1,'h1000,1,'h2000,1,'h3000,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0));
        repeat (2) @(negedge clk);
        #1;
        check("reset i_rd_ready", 32'(bus.i_rd_ready), 0);
        check("reset d_wr_ready", 32'(bus.d_wr_ready), 0);
        check("reset c_rd_valid", 32'(bus.c_rd_valid), 0);
        check("reset c_wr_valid", 32'(bus.c_wr_valid), 0);
        check("reset c_rd_addr", bus.c_rd_addr, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            row = i;
            @(negedge clk);
            drive(vecs[i]);
            #1;
            compare(vecs[i]);
        end

        // Reset asserted asynchronously while in RD_RESP with data arriving
        row = 1000;
        @(negedge clk);
        drive(mk(1,1,'h7000,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0));
        #1 check("seq grant I", 32'(bus.i_rd_ready), 1);
        @(negedge clk);
        drive(mk(1,0,0,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,0,0));
        #1 check("seq c_rd_addr", bus.c_rd_addr, 'h7000);
        @(negedge clk);
        drive(mk(1,1,'h7100,0,0,0,0,0,0,0,'h11112222,1,0, 0,0,0,0,0,0,0,0,0,0,0));
        #1 check("seq resp i_rd_data_valid", 32'(bus.i_rd_data_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async rst i_rd_data_valid", 32'(bus.i_rd_data_valid), 0);
        check("async rst i_rd_ready", 32'(bus.i_rd_ready), 0);
        check("async rst c_rd_valid", 32'(bus.c_rd_valid), 0);
        check("async rst c_wr_valid", 32'(bus.c_wr_valid), 0);
        @(negedge clk);
        row = 1001;
        drive(mk(1,0,0,0,0,0,0,0,0,0,'h33334444,1,0, 0,0,0,0,0,0,0,0,0,0,0));
        #1;
        check("stray i_rd_data_valid", 32'(bus.i_rd_data_valid), 0);
        check("stray d_rd_data_valid", 32'(bus.d_rd_data_valid), 0);
        check("stray c_rd_valid", 32'(bus.c_rd_valid), 0);
        @(negedge clk);
        row = 1002;
        drive(mk(1,1,'h8000,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0));
        #1 check("post-reset i_rd_ready", 32'(bus.i_rd_ready), 1);
        @(negedge clk);
        drive(z);
        #1;
        check("post-reset c_rd_valid", 32'(bus.c_rd_valid), 1);
        check("post-reset c_rd_addr", bus.c_rd_addr, 'h8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
